// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and sizing helpers for the async FIFO read side.
package fifo_pkg;

   localparam int DATA_WIDTH = 8;

   typedef enum logic [1:0] {FILL, HOLD, FLUSH} rd_pack_state_t;

   function automatic int cnt_width(input int pack);
      return $clog2(pack) + 1;
   endfunction

endpackage

// File: rtl/fifo_out_slot.sv
// fifo_out_slot: one-entry valid/ready output register for the read packer.
// slot_free_o tells the packer a new word may be loaded on this edge.
module fifo_out_slot
   import fifo_pkg::*;
#(
   parameter int W = 4 * DATA_WIDTH,
   parameter int K = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic [K-1:0] keep_i,
   input  logic         ready_i,
   output logic [W-1:0] data_o,
   output logic [K-1:0] keep_o,
   output logic         valid_o,
   output logic         slot_free_o
);

   logic [W-1:0] data_q;
   logic [K-1:0] keep_q;
   logic         valid_q;

   assign slot_free_o = !valid_q || ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         keep_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         keep_q  <= keep_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign data_o  = data_q;
   assign keep_o  = keep_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains FIFO entries and packs PACK of them per output word.
// Define FLUSH_TIMEOUT_EN to flush partial words after TIMEOUT idle cycles.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int data_width = DATA_WIDTH,
   parameter int PACK       = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                       rclk,
   input  logic                       r_rst,
   input  logic                       empty,
   output logic                       r_en,
   input  logic [data_width-1:0]      data_out,
   output logic [PACK*data_width-1:0] m_data,
   output logic [PACK-1:0]            m_keep,
   output logic                       m_valid,
   input  logic                       m_ready
);

   localparam int CW = cnt_width(PACK);
   localparam int LW = $clog2(PACK);
   localparam int WW = PACK * data_width;
   localparam logic [CW-1:0] FULL = CW'(PACK);
   localparam logic [CW-1:0] LAST = CW'(PACK - 1);

   if (PACK < 2 || (PACK & (PACK - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
      $error("fifo_rd_packer: PACK must be a power of 2 >= 2, TIMEOUT >= 1");
   end

   rd_pack_state_t state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           rd_pend_q;
   logic [WW-1:0]  pack_q, pack_d;
   logic [WW-1:0]  load_data;
   logic [PACK-1:0] load_keep;
   logic [LW-1:0]  lane;
   logic [CW:0]    in_flight;
   logic           slot_free, load, full_now, fill_last;
   logic           move_full, flushing, flush_go;

   // A word completes either already full or via the entry landing now.
   assign full_now  = (cnt_q == FULL);
   assign fill_last = (cnt_q == LAST) && rd_pend_q;
   assign move_full = (full_now || fill_last) && slot_free
                      && (state_q != FLUSH);
   assign in_flight = {1'b0, cnt_q} + {{CW{1'b0}}, rd_pend_q};

   assign r_en = !empty && !r_rst && (state_q != FLUSH)
                 && (in_flight < {1'b0, FULL} || move_full);

   assign load = move_full || flushing;

   always_comb begin
      load_data = pack_q;
      if (fill_last)
         load_data[WW-1 -: data_width] = data_out;
   end

`ifdef FLUSH_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT + 1);

   logic [IW-1:0] idle_q, idle_d;

   always_comb begin
      idle_d = '0;
      if (state_q == FILL && cnt_q != '0 && !full_now && !rd_pend_q)
         idle_d = (idle_q == IW'(TIMEOUT)) ? idle_q : idle_q + IW'(1);
   end

   // Defer the flush if a read is being issued; its capture restarts idling.
   assign flush_go = (idle_d == IW'(TIMEOUT)) && !r_en && (state_q == FILL);
   assign flushing = (state_q == FLUSH) && slot_free;

   always_comb begin
      load_keep = '1;
      if (flushing)
         for (int i = 0; i < PACK; i++)
            load_keep[i] = (CW'(i) < cnt_q);
   end

   always_ff @(posedge rclk) begin
      if (r_rst)
         idle_q <= '0;
      else
         idle_q <= idle_d;
   end
`else
   assign flush_go  = 1'b0;
   assign flushing  = 1'b0;
   assign load_keep = '1;
`endif

   always_comb begin
      pack_d  = pack_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      lane    = cnt_q[LW-1:0];
      if (load) begin
         pack_d = '0;
         cnt_d  = '0;
         lane   = '0;
      end
      if (rd_pend_q && !(load && fill_last)) begin
         pack_d[lane*data_width +: data_width] = data_out;
         cnt_d = cnt_d + CW'(1);
      end
      unique case (state_q)
         FLUSH:   state_d = flushing ? FILL : FLUSH;
         default: state_d = flush_go ? FLUSH
                            : ((cnt_d == FULL) ? HOLD : FILL);
      endcase
   end

   always_ff @(posedge rclk) begin
      if (r_rst) begin
         state_q   <= FILL;
         cnt_q     <= '0;
         rd_pend_q <= 1'b0;
         pack_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_pend_q <= r_en;
         pack_q    <= pack_d;
      end
   end

   fifo_out_slot #(
      .W (WW),
      .K (PACK)
   ) u_slot (
      .clk_i       (rclk),
      .rst_i       (r_rst),
      .load_i      (load),
      .data_i      (load_data),
      .keep_i      (load_keep),
      .ready_i     (m_ready),
      .data_o      (m_data),
      .keep_o      (m_keep),
      .valid_o     (m_valid),
      .slot_free_o (slot_free)
   );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: directed checks of the FIFO read packer with a FIFO model.
// Define FLUSH_TIMEOUT_EN to also exercise the partial-word flush.
module tb_fifo_rd_packer;

   logic        rclk = 1'b0;
   logic        r_rst, empty, r_en, m_valid, m_ready;
   logic [7:0]  data_out;
   logic [31:0] m_data;
   logic [3:0]  m_keep;

   always #5 rclk = ~rclk;

   fifo_rd_packer dut (
      .rclk     (rclk),
      .r_rst    (r_rst),
      .empty    (empty),
      .r_en     (r_en),
      .data_out (data_out),
      .m_data   (m_data),
      .m_keep   (m_keep),
      .m_valid  (m_valid),
      .m_ready  (m_ready)
   );

   logic [7:0]  src [0:63];
   int          rd_ptr = 0, avail = 0, cyc = 0;
   int          n_chk = 0, n_pass = 0, ren_viol = 0, hold_viol = 0;
   bit          toggle = 1'b0, hold_q = 1'b0, last_ren = 1'b0;
   logic [31:0] hold_d;
   logic [31:0] wq [$];
   logic [3:0]  kq [$];
   int          tq [$];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   // FIFO model: pops on a sampled r_en, data appears the next cycle
   task automatic tick();
      logic ren;
      @(negedge rclk);
      ren = r_en;
      if (ren && empty) ren_viol++;
      if (hold_q && !(m_valid && m_data == hold_d)) hold_viol++;
      hold_q = m_valid && !m_ready && !r_rst;
      hold_d = m_data;
      if (m_valid && m_ready && !r_rst) begin
         wq.push_back(m_data);
         kq.push_back(m_keep);
         tq.push_back(cyc);
      end
      last_ren = ren;
      @(posedge rclk);
      #1;
      cyc++;
      if (ren) begin
         data_out = src[rd_ptr[5:0]];
         rd_ptr++;
         if (avail > 0) avail--;
      end
      empty = (avail == 0) || (toggle && cyc[0]);
   endtask

   task automatic do_reset(input int n);
      r_rst = 1'b1;
      repeat (n) tick();
      r_rst = 1'b0;
      wq.delete();
      kq.delete();
      tq.delete();
   endtask

   initial begin
      for (int i = 0; i < 64; i++) src[i] = 8'(17 * (i + 1));
      r_rst    = 1'b1;
      empty    = 1'b0;
      m_ready  = 1'b0;
      data_out = '0;
      avail    = 1000;

      for (int i = 0; i < 3; i++) begin
         @(negedge rclk);
         chk("t1_ren", r_en, 0);
         chk("t1_valid", m_valid, 0);
         chk("t1_data", m_data, 0);
         chk("t1_keep", m_keep, 0);
         @(posedge rclk);
         #1;
      end
      m_ready = 1'b1;
      r_rst   = 1'b0;
      rd_ptr  = 0;
      tick();
      chk("t1_first_ren", last_ren, 1);

      for (int i = 0; i < 30 && wq.size() < 2; i++) tick();
      chk("t2_count", wq.size(), 2);
      chk("t2_w0", wq[0], 32'h44332211);
      chk("t2_w1", wq[1], 32'h88776655);
      chk("t2_keep0", kq[0], 4'hF);
      chk("t2_keep1", kq[1], 4'hF);
      chk("t2_gap", tq[1] - tq[0], 4);

      m_ready = 1'b0;
      do_reset(2);
      rd_ptr = 0;
      for (int i = 0; i < 20 && !m_valid; i++) tick();
      repeat (10) tick();
      chk("t3_hold_data", m_data, 32'h44332211);
      chk("t3_hold_valid", m_valid, 1);
      chk("t3_reads", rd_ptr, 8);
      chk("t3_hold_ren", last_ren, 0);
      m_ready = 1'b1;
      for (int i = 0; i < 30 && wq.size() < 3; i++) tick();
      chk("t3_count", wq.size(), 3);
      chk("t3_w0", wq[0], 32'h44332211);
      chk("t3_w1", wq[1], 32'h88776655);
      chk("t3_w2", wq[2], 32'hCCBBAA99);

      do_reset(2);
      rd_ptr = 0;
      toggle = 1'b1;
      repeat (41) tick();
      toggle = 1'b0;
      avail  = 0;
      empty  = 1'b1;
      repeat (8) tick();
      chk("t4_words", wq.size(), rd_ptr / 4);
      chk("t4_w0", wq[0], 32'h44332211);
      chk("t4_w1", wq[1], 32'h88776655);

      m_ready = 1'b0;
      do_reset(2);
      rd_ptr = 0;
      avail  = 6;
      empty  = 1'b0;
      repeat (15) tick();
      chk("t5_pre_valid", m_valid, 1);
      chk("t5_pre_reads", rd_ptr, 6);
      do_reset(1);
      chk("t5_post_valid", m_valid, 0);
      avail   = 4;
      empty   = 1'b0;
      m_ready = 1'b1;
      repeat (16) tick();
      chk("t5_count", wq.size(), 1);
      chk("t5_w0", wq[0], 32'hAA998877);

`ifdef FLUSH_TIMEOUT_EN
      do_reset(2);
      rd_ptr = 0;
      src[0] = 8'hA1;
      src[1] = 8'hB2;
      src[2] = 8'hC3;
      avail  = 3;
      empty  = 1'b0;
      for (int i = 0; i < 60 && wq.size() < 1; i++) tick();
      chk("t6_count", wq.size(), 1);
      chk("t6_data", wq[0], 32'h00C3B2A1);
      chk("t6_keep", kq[0], 4'b0111);
`endif

      chk("ren_while_empty", ren_viol, 0);
      chk("hold_stable", hold_viol, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
